midi_writer: RTL
================

Name: midi_writer

Overview:
- Serialises MIDI channel-voice messages onto a UART TX line at 31250 baud, 8N1; the transmit-side counterpart of midi_reader.
- Accepts one message (status nibble, channel, two data bytes) through a valid/ready handshake and emits 2 or 3 bytes back-to-back, depending on message type.
- Sits in the clk_100mhz domain and drives the FPGA-to-computer UART pin, for example to echo or forward notes to a host synth.

Parameters:
- BAUD_DIV, 3200, clock cycles per UART bit (100 MHz / 31250); must be >= 4.

Ports:
- clk_in  input  1  system clock (100 MHz)
- rst_in  input  1  asynchronous, active-low reset
- status_in  input  4  message type, the upper nibble of the status byte (0x8..0xE valid)
- channel_in  input  4  MIDI channel, the lower nibble of the status byte
- data_byte1_in  input  8  first data byte; bit 7 is forced to 0 on transmit
- data_byte2_in  input  8  second data byte; bit 7 is forced to 0; ignored for 2-byte messages
- valid_in  input  1  message present
- ready_out  output  1  writer idle and able to accept a message
- tx_wire_out  output  1  UART serial output, idle high
- busy_out  output  1  a frame is in progress
- drop_out  output  1  one-cycle pulse: message rejected because of an invalid status

Behaviour:
- Reset (rst_in=0, asynchronous): tx_wire_out=1, ready_out=0, busy_out=0, drop_out=0, state=IDLE, all counters 0.
  - Any frame in progress aborts immediately; tx_wire_out goes high without waiting for a clock.
  - ready_out rises on the first clk_in edge after rst_in deasserts.
- Handshake:
  - A message is accepted on a rising edge where valid_in=1 and ready_out=1.
  - All inputs are registered at acceptance; later changes to the inputs have no effect.
  - valid_in while ready_out=0 is ignored; nothing is queued.
- Message length:
  - status_in 0x8, 0x9, 0xA, 0xB, 0xE: 3 bytes.
  - status_in 0xC, 0xD: 2 bytes.
  - status_in 0x0..0x7 or 0xF: invalid. drop_out=1 for exactly the cycle after acceptance, no transmission, ready_out stays 1.
- Byte order: {status_in, channel_in}, then {1'b0, data_byte1_in[6:0]}, then {1'b0, data_byte2_in[6:0]}.
- Frame format: start bit (0), 8 data bits LSB first, stop bit (1); each bit is held for exactly BAUD_DIV cycles.
- Timing:
  - No idle gap between bytes of one message; byte k+1's start bit follows byte k's stop bit directly.
  - Latency: tx_wire_out goes low on the edge after acceptance.
  - A 3-byte message occupies 30*BAUD_DIV cycles; a 2-byte message occupies 20*BAUD_DIV cycles.
- FSM states and transitions:
  - IDLE -> START on a valid accept.
  - START -> DATA after BAUD_DIV cycles.
  - DATA: 8 bits, with a bit index 0..7.
  - STOP -> START if bytes remain, otherwise STOP -> IDLE.
- Counters:
  - baud counter 0..BAUD_DIV-1, wraps to 0 at each bit boundary.
  - bit index 0..7.
  - byte index 0..2.
- Outputs per state:
  - ready_out=1 only in IDLE; it re-asserts the cycle after the final stop bit completes.
  - busy_out = !IDLE.
  - Back-to-back messages are possible: valid_in held high is accepted in the first IDLE cycle.
- Simultaneous valid_in and reset: reset wins; the message is lost.

Optional Feature:
- Macro: MIDI_RUNNING_STATUS_EN.
- Defined:
  - The block keeps last_status (9 bits: a valid flag plus the byte), cleared on reset.
  - If an accepted valid message has a status byte equal to last_status, the status byte is omitted: 3-byte types become 2 bytes and 2-byte types become 1 byte.
  - Otherwise the status byte is sent in full and last_status is updated.
  - An invalid message (drop_out) clears the valid flag.
- Undefined: the status byte is always sent; no last_status register exists.

Test Plan (bench uses BAUD_DIV=8):
- Note-on, status 0x9, ch 0, d1 0x3C, d2 0x64 -> wire carries 0x90, 0x3C, 0x64 LSB-first 8N1; ready_out low for exactly 240 cycles; tx low on the cycle after accept.
- Program change, status 0xC, ch 5, d1 0x07, d2 0x55 -> bytes 0xC5, 0x07 only (160 cycles); d2 is never sent.
- Masking: d1 0xBC, d2 0xFF with status 0x8 -> data bytes 0x3C and 0x7F.
- Invalid status 0xF, valid_in=1 -> drop_out high for 1 cycle, tx_wire_out stays 1, ready_out stays 1.
- Protocol hazards:
  - Second valid_in pulse 50 cycles into a frame -> ignored, frame unchanged.
  - rst_in low mid-data-bit -> tx_wire_out=1 asynchronously, ready_out=0, then 1 on the first edge after release.
- With MIDI_RUNNING_STATUS_EN: two consecutive note-ons on ch 0 -> first message 3 bytes, second 2 bytes (0x3C, 0x64); a following note-off 0x80 -> 3 bytes again.

Source files
------------

// File: rtl/midi_writer.sv
`default_nettype none
// ============================================================================
// Module   : midi_writer
// Brief    : Serialises MIDI channel-voice messages (2 or 3 bytes) onto a
//            UART 8N1 line, BAUD_DIV clocks per bit. Optional build macro
//            MIDI_RUNNING_STATUS_EN omits a repeated status byte.
// Revision : 1.0 - initial release
// ============================================================================
module midi_writer #(
  parameter int BAUD_DIV = 3200
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [3:0] status_in,
  input  logic [3:0] channel_in,
  input  logic [7:0] data_byte1_in,
  input  logic [7:0] data_byte2_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       tx_wire_out,
  output logic       busy_out,
  output logic       drop_out
);

  localparam int                 c_CNT_W     = $clog2(BAUD_DIV);
  localparam logic [c_CNT_W-1:0] c_BAUD_LAST = c_CNT_W'(BAUD_DIV - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_CNT_W-1:0] r_baud_cnt;
  logic [c_CNT_W-1:0] w_baud_cnt_nxt;
  logic [2:0]         r_bit_idx;
  logic [2:0]         w_bit_idx_nxt;
  logic [2:0]         w_bit_idx_inc;
  logic [1:0]         r_byte_idx;
  logic [1:0]         w_byte_idx_nxt;
  logic [1:0]         r_last_idx;
  logic [1:0]         w_last_idx_nxt;
  logic [7:0]         r_byte0;
  logic [7:0]         r_byte1;
  logic [7:0]         r_byte2;
  logic [7:0]         w_cur_byte;
  logic               r_tx;
  logic               w_tx_nxt;
  logic               r_drop;
  logic               w_drop_nxt;
  logic               r_rdy_en;

  logic               w_idle;
  logic               w_accept;
  logic               w_load;
  logic               w_status_ok;
  logic               w_two_byte;
  logic               w_bit_end;
  logic               w_more_bytes;
  logic               w_skip_status;
  logic [7:0]         w_status_byte;
  logic               w_unused_bits;

  assign w_idle        = (r_state == S_IDLE);
  assign w_accept      = w_idle && r_rdy_en && valid_in;
  assign w_status_ok   = status_in[3] && (status_in != 4'hF);
  assign w_two_byte    = (status_in == 4'hC) || (status_in == 4'hD);
  assign w_load        = w_accept && w_status_ok;
  assign w_status_byte = {status_in, channel_in};
  assign w_bit_end     = (r_baud_cnt == c_BAUD_LAST);
  assign w_more_bytes  = (r_byte_idx != r_last_idx);
  assign w_bit_idx_inc = r_bit_idx + 3'd1;
  assign w_unused_bits = data_byte1_in[7] ^ data_byte2_in[7];

  always_comb begin
    w_cur_byte = r_byte2;
    case (r_byte_idx)
      2'd0:    w_cur_byte = r_byte0;
      2'd1:    w_cur_byte = r_byte1;
      default: w_cur_byte = r_byte2;
    endcase
  end

`ifdef MIDI_RUNNING_STATUS_EN
  // {valid, status byte} of the last status actually put on the wire
  logic [8:0] r_last_status;
  logic [8:0] w_last_status_nxt;

  assign w_skip_status = (r_last_status == {1'b1, w_status_byte});

  always_comb begin
    w_last_status_nxt = r_last_status;
    if (w_accept) begin
      if (w_status_ok) begin
        w_last_status_nxt = {1'b1, w_status_byte};
      end else begin
        w_last_status_nxt[8] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_last_status <= 9'd0;
    end else begin
      r_last_status <= w_last_status_nxt;
    end
  end
`else
  assign w_skip_status = 1'b0;
`endif

  // The TX level is computed for the bit that the next state will hold,
  // so the pin is a clean register output.
  always_comb begin
    w_state_nxt    = r_state;
    w_baud_cnt_nxt = r_baud_cnt;
    w_bit_idx_nxt  = r_bit_idx;
    w_byte_idx_nxt = r_byte_idx;
    w_last_idx_nxt = r_last_idx;
    w_tx_nxt       = r_tx;
    w_drop_nxt     = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_baud_cnt_nxt = '0;
        w_bit_idx_nxt  = 3'd0;
        w_tx_nxt       = 1'b1;
        if (w_accept) begin
          if (w_status_ok) begin
            w_state_nxt    = S_START;
            w_tx_nxt       = 1'b0;
            w_byte_idx_nxt = w_skip_status ? 2'd1 : 2'd0;
            w_last_idx_nxt = w_two_byte ? 2'd1 : 2'd2;
          end else begin
            w_drop_nxt = 1'b1;
          end
        end
      end

      S_START: begin
        w_baud_cnt_nxt = w_bit_end ? '0 : r_baud_cnt + c_CNT_ONE;
        if (w_bit_end) begin
          w_state_nxt   = S_DATA;
          w_bit_idx_nxt = 3'd0;
          w_tx_nxt      = w_cur_byte[0];
        end
      end

      S_DATA: begin
        w_baud_cnt_nxt = w_bit_end ? '0 : r_baud_cnt + c_CNT_ONE;
        if (w_bit_end) begin
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = S_STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_bit_idx_nxt = w_bit_idx_inc;
            w_tx_nxt      = w_cur_byte[w_bit_idx_inc];
          end
        end
      end

      S_STOP: begin
        w_baud_cnt_nxt = w_bit_end ? '0 : r_baud_cnt + c_CNT_ONE;
        if (w_bit_end) begin
          if (w_more_bytes) begin
            w_state_nxt    = S_START;
            w_byte_idx_nxt = r_byte_idx + 2'd1;
            w_tx_nxt       = 1'b0;
          end else begin
            w_state_nxt    = S_IDLE;
            w_byte_idx_nxt = 2'd0;
            w_tx_nxt       = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_baud_cnt <= '0;
      r_bit_idx  <= 3'd0;
      r_byte_idx <= 2'd0;
      r_last_idx <= 2'd0;
      r_tx       <= 1'b1;
      r_drop     <= 1'b0;
      r_rdy_en   <= 1'b0;
    end else begin
      r_baud_cnt <= w_baud_cnt_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_byte_idx <= w_byte_idx_nxt;
      r_last_idx <= w_last_idx_nxt;
      r_tx       <= w_tx_nxt;
      r_drop     <= w_drop_nxt;
      r_rdy_en   <= 1'b1;
    end
  end

  // Message payload is captured once at acceptance and held for the frame
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_byte0 <= 8'd0;
      r_byte1 <= 8'd0;
      r_byte2 <= 8'd0;
    end else if (w_load) begin
      r_byte0 <= w_status_byte;
      r_byte1 <= {1'b0, data_byte1_in[6:0]};
      r_byte2 <= {1'b0, data_byte2_in[6:0]};
    end
  end

  assign ready_out   = r_rdy_en && w_idle;
  assign busy_out    = !w_idle;
  assign tx_wire_out = r_tx;
  assign drop_out    = r_drop;

endmodule
`default_nettype wire
